// File: rtl/ahbgpio_param_pkg.sv
// Shared definitions for the parametrised AHB-Lite GPIO: register offsets,
// the registered address-phase record and the parity helper.
package ahbgpio_param_pkg;

  localparam logic [7:0] DATA_OFS  = 8'h00;
  localparam logic [7:0] DIR_OFS   = 8'h04;
  localparam logic [7:0] IEN_OFS   = 8'h08;
  localparam logic [7:0] ISTAT_OFS = 8'h0C;
  localparam logic [7:0] PERR_OFS  = 8'h10;
  localparam logic [7:0] IPOL_OFS  = 8'h14;

  typedef struct packed {
    logic [7:0] addr;
    logic       write;
    logic       valid;
  } aphase_t;

  // Expected parity bit: XOR of the zero-extended data, inverted for odd parity.
  function automatic logic par_bit(input logic [31:0] d, input logic sel);
    return (^d) ^ sel;
  endfunction

endpackage

// File: rtl/ahbgpio_param_sync_edge.sv
// Input synchroniser chain plus one-cycle history; reports the synchronised
// pins and a raw per-bit change mask.
module gpio_sync_edge #(
  parameter int WIDTH       = 17,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] chg
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign chg     = in_sync ^ prev_q;

endmodule

// File: rtl/ahbgpio_param.sv
// Parametrised AHB-Lite GPIO with per-bit direction, edge interrupts and
// sticky input parity error. Define AHBGPIO_EDGE_POL_EN to add the IPOL register.
module ahbgpio_param
  import ahbgpio_param_pkg::*;
#(
  parameter int GPIO_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  input  logic [GPIO_WIDTH:0]   GPIOIN,
  output logic [GPIO_WIDTH:0]   GPIOOUT,
  output logic [GPIO_WIDTH-1:0] GPIODIR,
  input  logic                  PARITYSEL,
  output logic                  PARITYERR,
  output logic                  IRQ
);

  localparam int W = GPIO_WIDTH;

  aphase_t      aph_q, aph_d;
  logic [W-1:0] dout_q, dout_d, dir_q, dir_d, ien_q, ien_d, istat_q, istat_d;
  logic         perr_q, perr_d, irq_q, irq_d;
  logic [W:0]   in_sync, chg;
  logic [W-1:0] wdata, istat_clr, edge_v;
  logic         wr, perr_clr;
  logic [31:0]  in_ext, dout_ext, rdata;
`ifdef AHBGPIO_EDGE_POL_EN
  logic [W-1:0] ipol_q, ipol_d;
`endif

  gpio_sync_edge #(.WIDTH(W+1), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (HCLK),
    .rst_n  (HRESETn),
    .din    (GPIOIN),
    .in_sync(in_sync),
    .chg    (chg)
  );

  always_comb begin
    aph_d = aph_q;
    if (HREADY) aph_d = '{addr: HADDR[7:0], write: HWRITE, valid: HSEL & HTRANS[1]};
    wr        = aph_q.valid & aph_q.write;
    wdata     = HWDATA[W-1:0];
    dout_d    = dout_q;
    dir_d     = dir_q;
    ien_d     = ien_q;
    istat_clr = '0;
    perr_clr  = 1'b0;
`ifdef AHBGPIO_EDGE_POL_EN
    ipol_d    = ipol_q;
`endif
    if (wr) begin
      case (aph_q.addr)
        DATA_OFS:  dout_d    = wdata;
        DIR_OFS:   dir_d     = wdata;
        IEN_OFS:   ien_d     = wdata;
        ISTAT_OFS: istat_clr = wdata;
        PERR_OFS:  perr_clr  = HWDATA[0];
`ifdef AHBGPIO_EDGE_POL_EN
        IPOL_OFS:  ipol_d    = wdata;
`endif
        default: ;
      endcase
    end
    // Edges use the direction currently in force; flags already set survive a dir change.
    edge_v = chg[W-1:0] & ~dir_q;
`ifdef AHBGPIO_EDGE_POL_EN
    edge_v = edge_v & ~(in_sync[W-1:0] ^ ipol_q);
`endif
    istat_d = (istat_q & ~istat_clr) | edge_v;
    in_ext        = '0;
    in_ext[W-1:0] = in_sync[W-1:0];
    perr_d = (perr_q & ~perr_clr) | (in_sync[W] != par_bit(in_ext, PARITYSEL));
    irq_d  = |(istat_q & ien_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aph_q   <= '0;
      dout_q  <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      istat_q <= '0;
      perr_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      aph_q   <= aph_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      istat_q <= istat_d;
      perr_q  <= perr_d;
      irq_q   <= irq_d;
    end
  end

`ifdef AHBGPIO_EDGE_POL_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ipol_q <= '0;
    else          ipol_q <= ipol_d;
  end
`endif

  // Read data is muxed straight from the registers during the data phase.
  always_comb begin
    rdata = '0;
    if (aph_q.valid && !aph_q.write) begin
      case (aph_q.addr)
        DATA_OFS:  rdata[W-1:0] = (dir_q & dout_q) | (~dir_q & in_sync[W-1:0]);
        DIR_OFS:   rdata[W-1:0] = dir_q;
        IEN_OFS:   rdata[W-1:0] = ien_q;
        ISTAT_OFS: rdata[W-1:0] = istat_q;
        PERR_OFS:  rdata[0]     = perr_q;
`ifdef AHBGPIO_EDGE_POL_EN
        IPOL_OFS:  rdata[W-1:0] = ipol_q;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    dout_ext        = '0;
    dout_ext[W-1:0] = dout_q;
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign GPIOOUT   = {par_bit(dout_ext, PARITYSEL), dout_q};
  assign GPIODIR   = dir_q;
  assign PARITYERR = perr_q;
  assign IRQ       = irq_q;

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:8], HTRANS[0], HWDATA, chg[W]};

endmodule

// File: tb/tb_ahbgpio_param.sv
// Directed self-checking bench for ahbgpio_param (default 16-bit build).
module tb_ahbgpio_param;

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1, PARITYSEL = 1'b0;
  logic [31:0] HADDR = '0, HWDATA = '0;
  logic [1:0]  HTRANS = '0;
  logic        HREADYOUT, PARITYERR, IRQ;
  logic [31:0] HRDATA;
  logic [16:0] GPIOIN = '0, GPIOOUT;
  logic [15:0] GPIODIR;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] rd;

  ahbgpio_param dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .GPIOIN(GPIOIN), .GPIOOUT(GPIOOUT), .GPIODIR(GPIODIR),
    .PARITYSEL(PARITYSEL), .PARITYERR(PARITYERR), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {24'h0, a};
    @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {24'h0, a};
    @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; d = HRDATA;
  endtask

  task automatic test_reset;
    @(negedge HCLK); @(negedge HCLK);
    n_cmp++; if (GPIOOUT !== 17'h0) begin n_err++; $display("FAIL rst_gpioout got %h want 00000", GPIOOUT); end
    n_cmp++; if (GPIODIR !== 16'h0) begin n_err++; $display("FAIL rst_gpiodir got %h want 0000", GPIODIR); end
    n_cmp++; if ({IRQ, PARITYERR, HREADYOUT} !== 3'b001) begin n_err++; $display("FAIL rst_flags got %b want 001", {IRQ, PARITYERR, HREADYOUT}); end
    n_cmp++; if (HRDATA !== 32'h0) begin n_err++; $display("FAIL rst_hrdata got %h want 0", HRDATA); end
    HRESETn = 1'b1;
  endtask

  task automatic test_output;
    ahb_write(8'h04, 32'h0000_FFFF);
    ahb_write(8'h00, 32'h0000_A5A5);
    n_cmp++; if (GPIOOUT !== 17'h00000) begin n_err++; $display("FAIL out_before got %h want 00000", GPIOOUT); end
    @(negedge HCLK);
    n_cmp++; if (GPIOOUT !== 17'h0A5A5) begin n_err++; $display("FAIL out_after got %h want 0A5A5", GPIOOUT); end
    n_cmp++; if (GPIODIR !== 16'hFFFF) begin n_err++; $display("FAIL gpiodir got %h want FFFF", GPIODIR); end
    ahb_read(8'h00, rd);
    n_cmp++; if (rd !== 32'h0000A5A5) begin n_err++; $display("FAIL rd_data got %h want 0000A5A5", rd); end
    #1 PARITYSEL = 1'b1; #1;
    n_cmp++; if (GPIOOUT !== 17'h1A5A5) begin n_err++; $display("FAIL odd_par_out got %h want 1A5A5", GPIOOUT); end
    PARITYSEL = 1'b0;
  endtask

  task automatic test_input;
    ahb_write(8'h04, 32'h0);
    GPIOIN = 17'h11234;
    repeat (3) @(negedge HCLK);
    ahb_read(8'h00, rd);
    n_cmp++; if (rd !== 32'h00001234) begin n_err++; $display("FAIL rd_in got %h want 00001234", rd); end
    n_cmp++; if (PARITYERR !== 1'b0) begin n_err++; $display("FAIL perr_clean got %b want 0", PARITYERR); end
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h00001234) begin n_err++; $display("FAIL istat_in got %h want 00001234", rd); end
  endtask

  task automatic test_parity;
    GPIOIN = 17'h01234;
    repeat (4) @(negedge HCLK);
    n_cmp++; if (PARITYERR !== 1'b1) begin n_err++; $display("FAIL perr_set got %b want 1", PARITYERR); end
    GPIOIN = 17'h11234;
    repeat (4) @(negedge HCLK);
    n_cmp++; if (PARITYERR !== 1'b1) begin n_err++; $display("FAIL perr_sticky got %b want 1", PARITYERR); end
    ahb_read(8'h10, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL perr_reg got %h want 1", rd); end
    ahb_write(8'h10, 32'h1);
    @(negedge HCLK);
    n_cmp++; if (PARITYERR !== 1'b0) begin n_err++; $display("FAIL perr_clr got %b want 0", PARITYERR); end
  endtask

  task automatic test_irq;
    ahb_write(8'h0C, 32'h0000_FFFF);
    ahb_write(8'h08, 32'h1);
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL istat_cleared got %h want 0", rd); end
    GPIOIN = 17'h01235;
    repeat (3) @(negedge HCLK);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_early got %b want 0", IRQ); end
    @(negedge HCLK);
    n_cmp++; if (IRQ !== 1'b1) begin n_err++; $display("FAIL irq_set got %b want 1", IRQ); end
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL istat_edge got %h want 1", rd); end
    // The clear lands on the same edge the new flag is raised.
    GPIOIN = 17'h11234;
    ahb_write(8'h0C, 32'h1);
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL set_wins got %h want 1", rd); end
    ahb_write(8'h0C, 32'h1);
    repeat (2) @(negedge HCLK);
    n_cmp++; if (IRQ !== 1'b0) begin n_err++; $display("FAIL irq_clr got %b want 0", IRQ); end
    n_cmp++; if (PARITYERR !== 1'b0) begin n_err++; $display("FAIL perr_irq got %b want 0", PARITYERR); end
  endtask

  task automatic test_dir_mask;
    ahb_write(8'h04, 32'h1);
    GPIOIN = 17'h01235;
    repeat (4) @(negedge HCLK);
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL dir_mask got %h want 0", rd); end
    ahb_read(8'h00, rd);
    n_cmp++; if (rd !== 32'h00001235) begin n_err++; $display("FAIL mix_data got %h want 00001235", rd); end
    ahb_write(8'h18, 32'hFFFF);
    ahb_read(8'h18, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped got %h want 0", rd); end
  endtask

  task automatic test_back_to_back;
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h8;
    @(negedge HCLK); HWDATA = 32'h0000_00F3; HWRITE = 0;
    @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; rd = HRDATA;
    n_cmp++; if (rd !== 32'h000000F3) begin n_err++; $display("FAIL b2b got %h want 000000F3", rd); end
  endtask

  task automatic test_polarity;
`ifdef AHBGPIO_EDGE_POL_EN
    ahb_write(8'h04, 32'h0);
    ahb_write(8'h14, 32'h1);
    ahb_write(8'h0C, 32'hFFFF);
    GPIOIN = 17'h11234;
    repeat (4) @(negedge HCLK);
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL pol_fall got %h want 0", rd); end
    GPIOIN = 17'h01235;
    repeat (4) @(negedge HCLK);
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL pol_rise got %h want 1", rd); end
`else
    ahb_write(8'h14, 32'h1);
    ahb_read(8'h14, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ipol_absent got %h want 0", rd); end
`endif
  endtask

  task automatic test_reset_mid;
    PARITYSEL = 1'b1;
    @(negedge HCLK); HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0;
    @(negedge HCLK); HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'h5A5A;
    #2 HRESETn = 1'b0; #1;
    n_cmp++; if (GPIOOUT !== 17'h10000) begin n_err++; $display("FAIL rst_mid_out got %h want 10000", GPIOOUT); end
    n_cmp++; if ({IRQ, PARITYERR} !== 2'b00) begin n_err++; $display("FAIL rst_mid_flags got %b want 00", {IRQ, PARITYERR}); end
    GPIOIN = '0; PARITYSEL = 1'b0;
    @(negedge HCLK); @(negedge HCLK); HRESETn = 1'b1;
    ahb_read(8'h00, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_data got %h want 0", rd); end
    ahb_read(8'h04, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_dir got %h want 0", rd); end
    ahb_read(8'h0C, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_istat got %h want 0", rd); end
    n_cmp++; if (GPIOOUT !== 17'h0) begin n_err++; $display("FAIL rst_mid_out2 got %h want 00000", GPIOOUT); end
  endtask

  initial begin
    test_reset;
    test_output;
    test_input;
    test_parity;
    test_irq;
    test_dir_mask;
    test_back_to_back;
    test_polarity;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahbgpio_param.md
Name: ahbgpio_param

Overview:
- Parametrised AHB-Lite GPIO; next generation of the fixed 16-bit AHB GPIO.
- Adds generic width, per-bit direction, and an input synchroniser.
- Adds an edge-detect interrupt with enable/status registers and a sticky input parity error.
- AHB slave on the peripheral bus; HSEL comes from the system decoder; pins go to the pad ring.

Parameters:
- GPIO_WIDTH, 16, data pins excluding parity bit; legal 1..32.
- SYNC_STAGES, 2, input synchroniser flop depth; legal >=2.

Ports:
- HCLK  in  1  bus clock; single clock domain.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only HADDR[7:0] decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 marks NONSEQ/SEQ.
- HWRITE  in  1  write strobe.
- HWDATA  in  32  write data, data phase.
- HREADY  in  1  bus ready.
- HREADYOUT  out  1  always 1; zero wait states.
- HRDATA  out  32  read data, data phase.
- GPIOIN  in  GPIO_WIDTH+1  pins; MSB = parity bit.
- GPIOOUT  out  GPIO_WIDTH+1  output data; MSB = generated parity.
- GPIODIR  out  GPIO_WIDTH  pad output enable; 1 = output.
- PARITYSEL  in  1  0 = even parity, 1 = odd parity.
- PARITYERR  out  1  sticky input parity error.
- IRQ  out  1  registered interrupt.

Behaviour:
- Transfer valid when HSEL & HTRANS[1] & HREADY.
- Address-phase HADDR[7:0] and HWRITE are registered; the register is written at the clock edge ending the data phase.
- Write latency: address phase in cycle N -> new value on GPIOOUT/GPIODIR/IRQ path from cycle N+2.
- Register map (offsets):
  - 0x00 DATA: W sets dout. R returns dir[i] ? dout[i] : in_sync[i].
  - 0x04 DIR: per-bit direction.
  - 0x08 IEN: interrupt enable.
  - 0x0C ISTAT: write-1-to-clear edge flags.
  - 0x10 PERR: bit0 sticky parity error, W1C.
- Unused HRDATA bits read 0. Unmapped offsets read 0; writes to them are ignored.
- Reset values: dout, dir, ien, istat, perr = 0. GPIOOUT[W-1:0] = 0. GPIOOUT[W] = PARITYSEL. GPIODIR = 0, IRQ = 0, PARITYERR = 0, HRDATA = 0, synchroniser flops = 0.
- GPIOOUT[W-1:0] = dout, driven regardless of dir. GPIOOUT[W] = ^dout ^ PARITYSEL, combinational.
- Input path:
  - GPIOIN passes through SYNC_STAGES flops, giving in_sync (W+1 bits).
  - prev = in_sync delayed 1 cycle.
  - edge[i] = (in_sync[i] != prev[i]) & ~dir[i].
- Interrupt status:
  - istat[i] is set on edge[i]. W1C clears it.
  - Simultaneous set and clear on the same bit: set wins.
- IRQ register <= |(istat & ien); one cycle behind istat.
- Parity error:
  - perr sets when in_sync[W] != (^in_sync[W-1:0] ^ PARITYSEL). W1C clears it; set wins.
  - PARITYERR = perr.
- Direction changes take effect on the next edge calculation. Switching a bit to output stops new edges on that bit but leaves existing istat intact.
- Back-to-back write then read of the same register returns the new value; no bypass needed.
- HRESETn low at any time, including mid-transfer: all state clears immediately; the in-flight transfer is discarded.

Optional Feature:
- Macro: AHBGPIO_EDGE_POL_EN.
- When defined:
  - Adds register 0x14 IPOL, reset 0, per bit: 1 = rising edge, 0 = falling edge.
  - edge[i] additionally requires in_sync[i] == IPOL[i].
- When undefined:
  - Any transition flags an edge.
  - Offset 0x14 is unmapped: reads 0, writes ignored.

Decomposition:
- Package ahbgpio_param_pkg holds:
  - Offset localparams: DATA_OFS, DIR_OFS, IEN_OFS, ISTAT_OFS, PERR_OFS, IPOL_OFS.
  - Typedef for the registered address-phase struct (addr, write, valid).
  - Parity helper function.
- One sub-module: gpio_sync_edge. It is parametrised by width and SYNC_STAGES, contains the synchroniser and prev register, and outputs in_sync and raw change mask.

Test Plan:
1. Write DIR=0xFFFF, then DATA=0xA5A5, PARITYSEL=0 -> GPIOOUT = 17'h0A5A5 (parity 0) two cycles after the DATA address phase; read DATA returns 0x0000A5A5.
2. DIR=0, GPIOIN = 17'h11234 (parity 1, consistent with odd bit count 5) -> DATA read returns 0x1234 after SYNC_STAGES+1 cycles; PARITYERR stays 0.
3. GPIOIN = 17'h01234 with PARITYSEL=0 -> PARITYERR = 1 and stays 1 after the input is corrected; write PERR=1 -> PARITYERR = 0.
4. IEN=0x0001, toggle GPIOIN[0] -> ISTAT bit0 = 1, IRQ = 1 one cycle later. Write ISTAT=1 in the same cycle as a new edge -> bit stays 1. Write ISTAT=1 with no edge -> IRQ = 0.
5. Assert HRESETn low mid-write to DATA -> GPIOOUT = {PARITYSEL,16'h0} immediately; after release, read DATA/DIR/ISTAT = 0.
6. With AHBGPIO_EDGE_POL_EN, IPOL=1: falling edge on bit0 -> no flag; rising edge -> ISTAT bit0 = 1.
